// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: FSM state encoding and retry counter width.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    StResetPll = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } pll_state_e;

  localparam int unsigned RetryW = 3;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer with lock qualification, timeout retries and lock-loss handling.
// Define LOCK_LOSS_CNT_EN to add the saturating loss_count output.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              locked_in,
  input  logic              sw_reset_req,
  output logic              pll_rst,
  output logic              sys_rst,
  output logic              ready,
  output logic              fail,
`ifdef LOCK_LOSS_CNT_EN
  output logic [CNT_W-1:0]  loss_count,
`endif
  output logic [2:0]        state,
  output logic [RetryW-1:0] retry_count
);

  localparam int unsigned TMaxA  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned TMax   = (TMaxA > STABLE_CYCLES) ? TMaxA : STABLE_CYCLES;
  localparam int unsigned TimerW = (TMax > 1) ? $clog2(TMax) : 1;

  localparam logic [TimerW-1:0] RstLast    = TimerW'(RST_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] StableLast = TimerW'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryLimit = RetryW'(MAX_RETRIES);

  pll_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [RetryW-1:0] retry_q, retry_d, retry_inc;
  logic              pll_rst_q, sys_rst_q, ready_q, fail_q;
  logic              locked_s;
`ifdef LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0]  loss_q, loss_d;
`endif

  sync_2ff u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (locked_in),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_inc = (retry_q == '1) ? retry_q : retry_q + RetryW'(1);
`ifdef LOCK_LOSS_CNT_EN
    loss_d    = loss_q;
`endif
    // sw_reset_req overrides everything, including a simultaneous lock loss.
    if (sw_reset_req) begin
      state_d = StResetPll;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StResetPll: if (timer_q == RstLast) state_d = StWaitLock;
        StWaitLock: begin
          if (locked_s) begin
            state_d = StStable;
          end else if (timer_q == TimeoutLast) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RetryLimit) ? StFail : StResetPll;
          end
        end
        StStable: begin
          if (!locked_s) begin
            state_d = StWaitLock;
          end else if (timer_q == StableLast) begin
            state_d = StRun;
            retry_d = '0;
          end
        end
        StRun: begin
          if (!locked_s) begin
            state_d = StWaitLock;
`ifdef LOCK_LOSS_CNT_EN
            if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
`endif
          end
        end
        StFail:  state_d = StFail;
        default: state_d = StResetPll;
      endcase
    end
    timer_d = (sw_reset_req || (state_d != state_q)) ? '0 : timer_q + TimerW'(1);
  end

  // Outputs are registered from the next state so they move on the same edge as state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= StResetPll;
      timer_q   <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_d == StResetPll) || (state_d == StFail);
      sys_rst_q <= (state_d != StRun);
      ready_q   <= (state_d == StRun);
      fail_q    <= (state_d == StFail);
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) loss_q <= '0;
    else     loss_q <= loss_d;
  end

  assign loss_count = loss_q;
`endif

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign state       = state_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus random lock/restart traffic.
module tb_pll_lock_supervisor;

  localparam int unsigned RstC = 4;
  localparam int unsigned ToC  = 20;
  localparam int unsigned StC  = 8;
  localparam int unsigned MaxR = 2;
  localparam int unsigned CntW = 4;
  localparam int          LossMax = (1 << CntW) - 1;

  logic            refclk = 1'b0;
  logic            rst = 1'b1;
  logic            locked_in = 1'b0;
  logic            sw_reset_req = 1'b0;
  logic            pll_rst, sys_rst, ready, fail;
  logic [2:0]      state;
  logic [2:0]      retry_count;
`ifdef LOCK_LOSS_CNT_EN
  logic [CntW-1:0] loss_count;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: phase number, cycles spent in phase, attempts, losses, lock pipeline.
  int m_phase, m_elapsed, m_retries, m_losses;
  bit m_s1, m_s2;

  pll_lock_supervisor #(
    .RST_CYCLES    (RstC),
    .LOCK_TIMEOUT  (ToC),
    .STABLE_CYCLES (StC),
    .MAX_RETRIES   (MaxR),
    .CNT_W         (CntW)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .locked_in    (locked_in),
    .sw_reset_req (sw_reset_req),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fail         (fail),
`ifdef LOCK_LOSS_CNT_EN
    .loss_count   (loss_count),
`endif
    .state        (state),
    .retry_count  (retry_count)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_retries = 0; m_losses = 0;
    m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  task automatic model_step(input bit lk, input bit sw);
    int nxt;
    bit seen;
    seen = m_s2;
    nxt  = m_phase;
    if (sw) begin
      nxt = 0;
      m_retries = 0;
    end else begin
      case (m_phase)
        0: if (m_elapsed == RstC - 1) nxt = 1;
        1: begin
          if (seen) nxt = 2;
          else if (m_elapsed == ToC - 1) begin
            if (m_retries < 7) m_retries++;
            nxt = (m_retries == MaxR) ? 4 : 0;
          end
        end
        2: begin
          if (!seen) nxt = 1;
          else if (m_elapsed == StC - 1) begin
            nxt = 3;
            m_retries = 0;
          end
        end
        3: begin
          if (!seen) begin
            nxt = 1;
            if (m_losses < LossMax) m_losses++;
          end
        end
        default: nxt = 4;
      endcase
    end
    m_elapsed = (sw || nxt != m_phase) ? 0 : m_elapsed + 1;
    m_phase = nxt;
    m_s2 = m_s1;
    m_s1 = lk;
  endtask

  task automatic check_all();
    chk("state", state, m_phase);
    chk("pll_rst", pll_rst, (m_phase == 0 || m_phase == 4));
    chk("sys_rst", sys_rst, (m_phase != 3));
    chk("ready", ready, (m_phase == 3));
    chk("fail", fail, (m_phase == 4));
    chk("retry_count", retry_count, m_retries);
`ifdef LOCK_LOSS_CNT_EN
    chk("loss_count", loss_count, m_losses);
`endif
  endtask

  // Called at a falling edge; inputs change here, outputs are checked at the next falling edge.
  task automatic tick(input bit lk, input bit sw);
    locked_in = lk;
    sw_reset_req = sw;
    model_step(lk, sw);
    @(posedge refclk);
    @(negedge refclk);
    cyc++;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    locked_in = 1'b0;
    sw_reset_req = 1'b0;
    model_reset();
    @(posedge refclk);
    @(negedge refclk);
    check_all();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 40 && state != 3'd3; i++) tick(1'b1, 1'b0);
    chk("reach_run", state, 3);
  endtask

  initial begin
    bit lk;
    model_reset();
    @(negedge refclk);

    // Reset values and clean lock at cycle 10.
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst", sys_rst, 1);
    repeat (9) tick(1'b0, 1'b0);
    for (int i = 0; i < 40 && state != 3'd3; i++) tick(1'b1, 1'b0);
    chk("clean_run_cycle", cyc, 20);
    chk("clean_retry", retry_count, 0);

    // Two timeouts lead to FAIL after 48 cycles.
    do_reset();
    repeat (48) tick(1'b0, 1'b0);
    chk("timeout_state", state, 4);
    chk("timeout_retry", retry_count, 2);
    chk("timeout_fail", fail, 1);
    repeat (5) tick(1'b0, 1'b0);

    // Recovery via sw_reset_req.
    tick(1'b0, 1'b1);
    chk("recover_state", state, 0);
    chk("recover_fail", fail, 0);
    wait_run();

    // Glitch while qualifying.
    tick(1'b1, 1'b1);
    for (int i = 0; i < 20 && state != 3'd2; i++) tick(1'b1, 1'b0);
    chk("glitch_in_stable", state, 2);
    repeat (3) tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    chk("glitch_back_wait", state, 1);
    chk("glitch_retry", retry_count, 0);
    wait_run();

    // Repeated lock loss in RUN.
    for (int k = 0; k < 16; k++) begin
      repeat (3) tick(1'b0, 1'b0);
      chk("loss_sys_rst", sys_rst, 1);
      chk("loss_ready", ready, 0);
`ifdef LOCK_LOSS_CNT_EN
      chk("loss_count_step", loss_count, (k + 1 > LossMax) ? LossMax : k + 1);
`endif
      wait_run();
    end

    // Random lock toggling with occasional restarts.
    lk = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) lk = ~lk;
      tick(lk, ($urandom_range(0, 149) == 0));
    end

    // Asynchronous reset between edges while running.
    tick(1'b0, 1'b1);
    wait_run();
    #2 rst = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_pll_rst", pll_rst, 1);
    chk("async_sys_rst", sys_rst, 1);
    chk("async_ready", ready, 0);
    chk("async_retry", retry_count, 0);
`ifdef LOCK_LOSS_CNT_EN
    chk("async_loss", loss_count, 0);
`endif
    model_reset();
    @(negedge refclk);
    rst = 1'b0;
    check_all();
    repeat (5) tick(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
